// File: rtl/p_uart_pkg.sv
// rtl/p_uart_pkg.sv - shared modes, send FSM states and byte transform for the packet loop
package p_uart_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_REV  = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_INC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_END
    } state_t;

    // Per-byte value change; byte reversal is a reordering and is done by the caller.
    function automatic logic [7:0] xform_byte(input logic [1:0] mode, input logic [7:0] b);
        logic [7:0] r;
        case (mode)
            MODE_PASS, MODE_REV: r = b;
            MODE_INV:            r = ~b;
            MODE_INC:            r = b + 8'd1;
            default:             r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/p_uart_pkt_loop_if.sv
// rtl/p_uart_pkt_loop_if.sv - receiver/transmitter/status signal bundle for the packet loop
interface p_uart_pkt_loop_if #(
    parameter int PKT_BYTES = 16,
    parameter int DEPTH     = 4,
    parameter int DROP_W    = 8
);
    localparam int W  = 8 * PKT_BYTES;
    localparam int LW = $clog2(DEPTH) + 1;

    logic              recv_done;
    logic [W-1:0]      recv_data;
    logic [1:0]        mode;
    logic              tx_busy;
    logic              send_en;
    logic [W-1:0]      send_data;
    logic [LW-1:0]     fifo_level;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output recv_done, recv_data, mode, tx_busy,
        input  send_en, send_data, fifo_level, drop_cnt
    );

    modport slave (
        input  recv_done, recv_data, mode, tx_busy,
        output send_en, send_data, fifo_level, drop_cnt
    );

endinterface

// File: rtl/p_pkt_fifo.sv
// rtl/p_pkt_fifo.sv - W x DEPTH packet FIFO with combinational head read and extra-MSB pointers
module p_pkt_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/p_uart_pkt_loop.sv
// rtl/p_uart_pkt_loop.sv - buffers received packets, transforms them at pop and retransmits via en/busy
module p_uart_pkt_loop
    import p_uart_pkg::*;
#(
    parameter int PKT_BYTES = 16,
    parameter int DEPTH     = 4,
    parameter int START_TO  = 1023,
    parameter int DROP_W    = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    p_uart_pkt_loop_if.slave   io
);
    localparam int W  = 8 * PKT_BYTES;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(START_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(START_TO - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              send_en_q, send_en_d;
    logic [W-1:0]      send_data_q, send_data_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic          push, pop, full, empty;
    logic [W-1:0]  head;
    logic [LW-1:0] level;

    function automatic logic [W-1:0] xform(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        int src;
        for (int i = 0; i < PKT_BYTES; i++) begin
            src = (m == MODE_REV) ? (PKT_BYTES - 1 - i) : i;
            r[8*i +: 8] = xform_byte(m, d[8*src +: 8]);
        end
        return r;
    endfunction

    p_pkt_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .wdata (io.recv_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        send_en_d   = 1'b0;
        send_data_d = send_data_q;
        drop_cnt_d  = drop_cnt_q;

        pop  = (state_q == IDLE) && !empty && !io.tx_busy;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push = io.recv_done && (!full || pop);

        if (io.recv_done && !push && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    send_en_d   = 1'b1;
                    send_data_d = xform(head, io.mode);
                    to_cnt_d    = '0;
                    state_d     = WAIT_START;
                end
            end
            WAIT_START: begin
                if (io.tx_busy)                state_d  = WAIT_END;
                else if (to_cnt_q == TO_LAST)  state_d  = IDLE;
                else                           to_cnt_d = to_cnt_q + 1'b1;
            end
            WAIT_END: begin
                if (!io.tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            send_en_q   <= 1'b0;
            send_data_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            send_en_q   <= send_en_d;
            send_data_q <= send_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign io.send_en    = send_en_q;
    assign io.send_data  = send_data_q;
    assign io.fifo_level = level;
    assign io.drop_cnt   = drop_cnt_q;

endmodule
